// File: rtl/fifo_credit_tx.sv
// Transmit side of a credit-based link: forwards producer entries as registered
// beats to a remote fifo, spending one credit per beat and regaining one per return.
module fifo_credit_tx #(
    parameter int N_CREDITS   = 4,
    parameter int ENTRY_WIDTH = 4,
    localparam int CTR_WIDTH  = $clog2(N_CREDITS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [ENTRY_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   tx_valid,
    output logic [ENTRY_WIDTH-1:0] tx_data,
    input  logic                   credit_return,
    output logic [CTR_WIDTH-1:0]   current_credit_state,
    output logic                   credit_overflow_err
);

    localparam logic [CTR_WIDTH-1:0] CREDIT_MAX = CTR_WIDTH'(N_CREDITS);

    logic [CTR_WIDTH-1:0]   credit_q, credit_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [ENTRY_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                   err_q, err_d;
    logic                   send;
    logic [CTR_WIDTH:0]     credit_sum;

    always_comb begin
        in_ready   = (credit_q != '0) && !rst;
        send       = in_valid && in_ready;
        tx_valid_d = send;
        tx_data_d  = send ? in_data : tx_data_q;
        // One extra bit so a return at full credit is visible instead of wrapping.
        credit_sum = {1'b0, credit_q} - (CTR_WIDTH+1)'(send) + (CTR_WIDTH+1)'(credit_return);
        credit_d   = credit_q;
        err_d      = err_q;
        if (credit_sum > {1'b0, CREDIT_MAX}) begin
            credit_d = CREDIT_MAX;
            err_d    = 1'b1;
        end else begin
            credit_d = credit_sum[CTR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= CREDIT_MAX;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign tx_valid             = tx_valid_q;
    assign tx_data              = tx_data_q;
    assign current_credit_state = credit_q;
    assign credit_overflow_err  = err_q;

endmodule

// File: tb/tb_fifo_credit_tx.sv
// Bench for fifo_credit_tx: directed boundary steps followed by random traffic
// compared every cycle against a simple arithmetic credit model.
module tb_fifo_credit_tx;

    localparam int N  = 4;
    localparam int EW = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [EW-1:0] in_data;
    logic          in_ready;
    logic          tx_valid;
    logic [EW-1:0] tx_data;
    logic          credit_return;
    logic [CW-1:0] current_credit_state;
    logic          credit_overflow_err;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_credit = N;
    int m_txv    = 0;
    int m_txd    = 0;
    int m_err    = 0;

    fifo_credit_tx #(.N_CREDITS(N), .ENTRY_WIDTH(EW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .tx_valid             (tx_valid),
        .tx_data              (tx_data),
        .credit_return        (credit_return),
        .current_credit_state (current_credit_state),
        .credit_overflow_err  (credit_overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check in_ready before the edge, advance the model,
    // then check registered outputs just after the edge.
    task automatic cycle(input logic r, input logic v, input logic [EW-1:0] d, input logic cr);
        int exp_rdy;
        int snd;
        int c;
        rst = r; in_valid = v; in_data = d; credit_return = cr;
        #1;
        exp_rdy = (m_credit > 0 && !r) ? 1 : 0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        snd = (v && exp_rdy) ? 1 : 0;
        if (r) begin
            m_credit = N; m_txv = 0; m_txd = 0; m_err = 0;
        end else begin
            m_txv = snd;
            if (snd) m_txd = int'(d);
            c = m_credit - snd + int'(cr);
            if (c > N) begin
                c = N;
                m_err = 1;
            end
            m_credit = c;
        end
        @(posedge clk);
        #1;
        chk("tx_valid", 32'(tx_valid), 32'(m_txv));
        chk("tx_data", 32'(tx_data), 32'(m_txd));
        chk("credit", 32'(current_credit_state), 32'(m_credit));
        chk("overflow_err", 32'(credit_overflow_err), 32'(m_err));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_return = 1'b0;
        @(posedge clk); #1;

        // Reset then idle
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 4'hF, 0);
        chk("idle_credit", 32'(current_credit_state), 32'd4);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_txv", 32'(tx_valid), 32'd0);
        chk("idle_err", 32'(credit_overflow_err), 32'd0);

        // Drain all credits with data 1..4; 5th is refused
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1, EW'(i), 0);
            chk("drain_txd", 32'(tx_data), 32'(i));
            chk("drain_credit", 32'(current_credit_state), 32'(4 - i));
        end
        cycle(0, 1, 4'd5, 0);
        chk("zero_no_send", 32'(tx_valid), 32'd0);
        chk("zero_txd_hold", 32'(tx_data), 32'd4);

        // Return at zero: no bypass, credit 1 next cycle, then 5 goes out
        cycle(0, 1, 4'd5, 1);
        chk("ret_credit", 32'(current_credit_state), 32'd1);
        chk("ret_no_send", 32'(tx_valid), 32'd0);
        cycle(0, 1, 4'd5, 0);
        chk("send5_txd", 32'(tx_data), 32'd5);
        chk("send5_txv", 32'(tx_valid), 32'd1);
        chk("send5_credit", 32'(current_credit_state), 32'd0);

        // Simultaneous send and return at credit 2
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 4'hA, 1);
        chk("simul_credit", 32'(current_credit_state), 32'd2);
        chk("simul_txv", 32'(tx_valid), 32'd1);
        chk("simul_txd", 32'(tx_data), 32'hA);

        // Overflow at full credit, sticky through later traffic
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("ovf_credit", 32'(current_credit_state), 32'd4);
        chk("ovf_err", 32'(credit_overflow_err), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, EW'(i + 6), 0);
        chk("ovf_sticky", 32'(credit_overflow_err), 32'd1);
        chk("ovf_send_ok", 32'(tx_data), 32'd8);
        chk("ovf_credit1", 32'(current_credit_state), 32'd1);

        // Accept at credit 1, then reset the next cycle drops the beat
        cycle(0, 1, 4'hC, 0);
        chk("pre_rst_txv", 32'(tx_valid), 32'd1);
        cycle(1, 1, 4'hD, 0);
        chk("rst_txv", 32'(tx_valid), 32'd0);
        chk("rst_credit", 32'(current_credit_state), 32'd4);
        chk("rst_err", 32'(credit_overflow_err), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'd0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(199) == 0), 1'($urandom), EW'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
